alif_param_loader: RTL and testbench

//  Serial configuration front-end for the single-channel ALIF neuron; sits directly upstream of the neuron core.

---
 rtl/alif_cfg_pkg.sv | 35 +++
 rtl/sync_edge_det.sv | 32 +++
 rtl/alif_param_loader.sv | 126 ++++++++++++
 tb/tb_alif_param_loader.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/alif_cfg_pkg.sv
// Shared configuration constants for the ALIF neuron: frame layout, loader FSM
// encoding and the power-on parameter defaults also used by the neuron core.
package alif_cfg_pkg;

    localparam int FRAME_BITS = 33;

    localparam int THRESH_MSB = 32;
    localparam int THRESH_LSB = 25;
    localparam int LEAK_MSB   = 24;
    localparam int LEAK_LSB   = 17;
    localparam int AINC_MSB   = 16;
    localparam int AINC_LSB   = 9;
    localparam int ADEC_MSB   = 8;
    localparam int ADEC_LSB   = 5;
    localparam int REFRAC_MSB = 4;
    localparam int REFRAC_LSB = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } load_state_t;

    localparam logic [7:0] DEF_THRESH      = 8'd64;
    localparam logic [7:0] DEF_LEAK        = 8'd2;
    localparam logic [7:0] DEF_ADAPT_INC   = 8'd4;
    localparam logic [3:0] DEF_ADAPT_DECAY = 4'd3;
    localparam logic [3:0] DEF_REFRAC      = 4'd2;

    // Even parity over the whole frame, parity bit included.
    function automatic logic parity_even(input logic [FRAME_BITS-1:0] frame);
        return ~(^frame);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous pin, with single-cycle rise/fall
// strobes derived from the synchronized level.
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_r;
    logic              prev_r;

    // Synchronizer chain plus one delayed copy of its output for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_r <= '0;
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
            prev_r <= sync_r[STAGES-1];
        end
    end

    assign q    = sync_r[STAGES-1];
    assign rise = q & ~prev_r;
    assign fall = ~q & prev_r;

endmodule

// File: rtl/alif_param_loader.sv
// Serial configuration front-end for the ALIF neuron: shifts in a 33-bit frame,
// checks length and parity, and commits the whole parameter set atomically.
module alif_param_loader
    import alif_cfg_pkg::*;
#(
    parameter int         SYNC_STAGES     = 2,
    parameter logic [7:0] DEF_THRESH      = alif_cfg_pkg::DEF_THRESH,
    parameter logic [7:0] DEF_LEAK        = alif_cfg_pkg::DEF_LEAK,
    parameter logic [7:0] DEF_ADAPT_INC   = alif_cfg_pkg::DEF_ADAPT_INC,
    parameter logic [3:0] DEF_ADAPT_DECAY = alif_cfg_pkg::DEF_ADAPT_DECAY,
    parameter logic [3:0] DEF_REFRAC      = alif_cfg_pkg::DEF_REFRAC
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       load_mode,
    input  logic       sclk,
    input  logic       serial_data,
    output logic [7:0] thresh,
    output logic [7:0] leak,
    output logic [7:0] adapt_inc,
    output logic [3:0] adapt_decay,
    output logic [3:0] refrac,
    output logic       params_ready,
    output logic       params_update,
    output logic       load_err
);

    logic lm_q, lm_rise, lm_fall;
    logic sc_q_unused, sc_rise, sc_fall_unused;
    logic sd_q, sd_rise_unused, sd_fall_unused;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_lm (
        .clk(clk), .rst_n(rst_n), .d(load_mode),
        .q(lm_q), .rise(lm_rise), .fall(lm_fall)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_sc (
        .clk(clk), .rst_n(rst_n), .d(sclk),
        .q(sc_q_unused), .rise(sc_rise), .fall(sc_fall_unused)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_sd (
        .clk(clk), .rst_n(rst_n), .d(serial_data),
        .q(sd_q), .rise(sd_rise_unused), .fall(sd_fall_unused)
    );

    load_state_t           state_r, state_next;
    logic [FRAME_BITS-1:0] shadow_r;
    logic [5:0]            cnt_r;
    logic [7:0]            thresh_r, leak_r, adapt_inc_r;
    logic [3:0]            adapt_decay_r, refrac_r;
    logic                  ready_r, update_r, err_r;
    logic                  frame_ok_s, do_check_s, lm_level_unused;

    assign lm_level_unused = lm_q;
    assign frame_ok_s = (cnt_r == 6'(FRAME_BITS)) && parity_even(shadow_r);
    assign do_check_s = (state_r == CHECK) && ena;

    // Next-state logic; a dropped enable always returns the loader to IDLE.
    always_comb begin
        state_next = state_r;
        case (state_r)
            IDLE:    state_next = lm_rise ? SHIFT : IDLE;
            SHIFT:   state_next = lm_fall ? CHECK : SHIFT;
            CHECK:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (!ena) begin
            state_next = IDLE;
        end else begin
            state_next = state_next;
        end
    end

    // State, shadow frame, bit counter and the committed parameter set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            shadow_r      <= '0;
            cnt_r         <= 6'd0;
            thresh_r      <= DEF_THRESH;
            leak_r        <= DEF_LEAK;
            adapt_inc_r   <= DEF_ADAPT_INC;
            adapt_decay_r <= DEF_ADAPT_DECAY;
            refrac_r      <= DEF_REFRAC;
            ready_r       <= 1'b0;
            update_r      <= 1'b0;
            err_r         <= 1'b0;
        end else begin
            state_r <= state_next;
            if (!ena || (state_r == IDLE && lm_rise)) begin
                shadow_r <= '0;
                cnt_r    <= 6'd0;
            end else if (state_r == SHIFT && sc_rise && !lm_fall) begin
                // A strobe coincident with the end of frame is deliberately dropped.
                shadow_r <= {shadow_r[FRAME_BITS-2:0], sd_q};
                cnt_r    <= (cnt_r == 6'd63) ? cnt_r : cnt_r + 6'd1;
            end
            update_r <= do_check_s && frame_ok_s;
            if (do_check_s) begin
                if (frame_ok_s) begin
                    thresh_r      <= shadow_r[THRESH_MSB:THRESH_LSB];
                    leak_r        <= shadow_r[LEAK_MSB:LEAK_LSB];
                    adapt_inc_r   <= shadow_r[AINC_MSB:AINC_LSB];
                    adapt_decay_r <= shadow_r[ADEC_MSB:ADEC_LSB];
                    refrac_r      <= shadow_r[REFRAC_MSB:REFRAC_LSB];
                    ready_r       <= 1'b1;
                    err_r         <= 1'b0;
                end else begin
                    err_r <= 1'b1;
                end
            end
        end
    end

    assign thresh        = thresh_r;
    assign leak          = leak_r;
    assign adapt_inc     = adapt_inc_r;
    assign adapt_decay   = adapt_decay_r;
    assign refrac        = refrac_r;
    assign params_ready  = ready_r;
    assign params_update = update_r;
    assign load_err      = err_r;

endmodule

// File: tb/tb_alif_param_loader.sv
// Randomized bench for alif_param_loader: a frame-level model predicts the
// committed parameters and flags, checked against the DUT on every clock.
module tb_alif_param_loader;

    logic       clk = 1'b0;
    logic       rst_n, ena, load_mode, sclk, serial_data;
    logic [7:0] thresh, leak, adapt_inc;
    logic [3:0] adapt_decay, refrac;
    logic       params_ready, params_update, load_err;

    int checks = 0;
    int errors = 0;

    alif_param_loader dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .load_mode(load_mode),
        .sclk(sclk), .serial_data(serial_data),
        .thresh(thresh), .leak(leak), .adapt_inc(adapt_inc),
        .adapt_decay(adapt_decay), .refrac(refrac),
        .params_ready(params_ready), .params_update(params_update),
        .load_err(load_err)
    );

    always #5 clk = ~clk;

    // Model state: what the outputs must show after each clock edge.
    logic [7:0]  m_thresh, m_leak, m_ainc;
    logic [3:0]  m_adec, m_refrac;
    logic        m_ready, m_update, m_err;
    bit          started = 0;
    int          cyc = 0;
    bit          pend_on = 0;
    int          pend_at = 0;
    bit          pend_ok = 0;
    logic [32:0] pend_frame;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // Verdict of a frame takes effect four edges after load_mode falls at the pin.
    always @(posedge clk) begin
        cyc++;
        m_update = 1'b0;
        if (!rst_n) begin
            m_thresh = 8'd64; m_leak = 8'd2; m_ainc = 8'd4; m_adec = 4'd3; m_refrac = 4'd2;
            m_ready = 1'b0; m_err = 1'b0; pend_on = 0; started = 1;
        end else if (pend_on && cyc == pend_at) begin
            pend_on = 0;
            if (pend_ok) begin
                m_thresh = pend_frame[32:25]; m_leak = pend_frame[24:17];
                m_ainc = pend_frame[16:9]; m_adec = pend_frame[8:5]; m_refrac = pend_frame[4:1];
                m_ready = 1'b1; m_err = 1'b0; m_update = 1'b1;
            end else begin
                m_err = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("thresh", 32'(thresh), 32'(m_thresh));
            chk("leak", 32'(leak), 32'(m_leak));
            chk("adapt_inc", 32'(adapt_inc), 32'(m_ainc));
            chk("adapt_decay", 32'(adapt_decay), 32'(m_adec));
            chk("refrac", 32'(refrac), 32'(m_refrac));
            chk("params_ready", 32'(params_ready), 32'(m_ready));
            chk("params_update", 32'(params_update), 32'(m_update));
            chk("load_err", 32'(load_err), 32'(m_err));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [32:0] mk(input logic [7:0] th, input logic [7:0] lk,
                                       input logic [7:0] ai, input logic [3:0] ad,
                                       input logic [3:0] rf);
        logic [31:0] p;
        p = {th, lk, ai, ad, rf};
        return {p, ^p};
    endfunction

    // Sends the nbits low bits of 'bits', MSB first. abort_at>=0 drops ena at that bit.
    task automatic send_frame(input logic [63:0] bits, input int nbits,
                              input bit coincident, input int abort_at);
        logic [32:0] fr;
        bit          aborted = 0;
        int          par = 0;
        fr = bits[32:0];
        load_mode = 1'b1;
        tick(4);
        for (int i = 0; i < nbits; i++) begin
            if (i == abort_at) begin
                ena = 1'b0;
                aborted = 1;
            end
            serial_data = bits[nbits-1-i];
            par = par ^ int'(bits[nbits-1-i]);
            sclk = 1'b0;
            tick(3);
            sclk = 1'b1;
            tick(3);
        end
        sclk = 1'b0;
        serial_data = 1'b1;
        tick(3);
        if (coincident) sclk = 1'b1;
        load_mode = 1'b0;
        if (!aborted) begin
            pend_on = 1;
            pend_at = cyc + 4;
            pend_ok = (nbits == 33) && (par == 0);
            pend_frame = fr;
        end
        tick(2);
        sclk = 1'b0;
        tick(8);
        ena = 1'b1;
        tick(2);
    endtask

    initial begin
        logic [32:0] f2;
        logic [63:0] rnd;
        rst_n = 1'b0; ena = 1'b1; load_mode = 1'b0; sclk = 1'b0; serial_data = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        chk("def_thresh", 32'(thresh), 32'd64);
        chk("def_leak", 32'(leak), 32'd2);
        chk("def_ainc", 32'(adapt_inc), 32'd4);
        chk("def_adec", 32'(adapt_decay), 32'd3);
        chk("def_refrac", 32'(refrac), 32'd2);
        chk("def_ready", 32'(params_ready), 32'd0);
        chk("def_err", 32'(load_err), 32'd0);

        f2 = mk(8'hA5, 8'h11, 8'h07, 4'd5, 4'd9);
        send_frame({31'd0, f2}, 33, 1'b0, -1);
        chk("v_thresh", 32'(thresh), 32'hA5);
        chk("v_leak", 32'(leak), 32'h11);
        chk("v_ainc", 32'(adapt_inc), 32'h07);
        chk("v_adec", 32'(adapt_decay), 32'd5);
        chk("v_refrac", 32'(refrac), 32'd9);
        chk("v_ready", 32'(params_ready), 32'd1);

        send_frame({31'd0, f2 ^ 33'd1}, 33, 1'b0, -1);
        chk("par_err", 32'(load_err), 32'd1);
        chk("par_keep", 32'(thresh), 32'hA5);

        rnd = {$urandom(), $urandom()};
        send_frame(rnd, 32, 1'b0, -1);
        chk("short_err", 32'(load_err), 32'd1);
        rnd = {$urandom(), $urandom()};
        send_frame(rnd, 40, 1'b0, -1);
        chk("long_err", 32'(load_err), 32'd1);
        send_frame({31'd0, mk(8'h3C, 8'h01, 8'h02, 4'd1, 4'd7)}, 33, 1'b0, -1);
        chk("err_clear", 32'(load_err), 32'd0);
        chk("clr_thresh", 32'(thresh), 32'h3C);

        send_frame({31'd0, f2 ^ 33'd2}, 33, 1'b0, -1);
        send_frame({31'd0, mk(8'hFF, 8'hFF, 8'hFF, 4'hF, 4'hF)}, 33, 1'b0, 20);
        chk("abort_err", 32'(load_err), 32'd1);
        chk("abort_keep", 32'(thresh), 32'h3C);

        send_frame({31'd0, f2}, 33, 1'b0, -1);
        load_mode = 1'b1;
        tick(4);
        for (int i = 0; i < 10; i++) begin
            serial_data = 1'b1; sclk = 1'b0; tick(3); sclk = 1'b1; tick(3);
        end
        rst_n = 1'b0; load_mode = 1'b0; sclk = 1'b0;
        tick(1);
        chk("rst_thresh", 32'(thresh), 32'd64);
        chk("rst_refrac", 32'(refrac), 32'd2);
        chk("rst_ready", 32'(params_ready), 32'd0);
        rst_n = 1'b1;
        tick(4);

        send_frame({31'd0, mk(8'h5A, 8'h22, 8'h33, 4'd6, 4'd4)}, 33, 1'b1, -1);
        chk("coinc_thresh", 32'(thresh), 32'h5A);
        chk("coinc_err", 32'(load_err), 32'd0);

        for (int k = 0; k < 14; k++) begin
            int sel;
            logic [32:0] fr;
            sel = int'($urandom_range(0, 9));
            fr = mk(8'($urandom()), 8'($urandom()), 8'($urandom()),
                    4'($urandom()), 4'($urandom()));
            if (sel < 6) send_frame({31'd0, fr}, 33, sel[0], -1);
            else if (sel < 8) send_frame({31'd0, fr ^ 33'(1 << $urandom_range(0, 32))}, 33, 1'b0, -1);
            else send_frame({$urandom(), $urandom()}, 30 + int'($urandom_range(0, 10)) * ((sel == 8) ? 1 : 0) + ((sel == 9) ? 34 - 30 : 0), 1'b0, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
